// File: rtl/riscv_mpsoc_pkg.sv
// riscv_mpsoc_pkg: shared BIU burst-type encodings, beat-count helper and arbiter state type
// Contents: BIU_* burst type codes, biu_type2cnt (beats-1 per burst type), biu_arb_state_t
package riscv_mpsoc_pkg;
  localparam logic [2:0] BIU_SINGLE = 3'b000;
  localparam logic [2:0] BIU_INCR   = 3'b001;
  localparam logic [2:0] BIU_WRAP4  = 3'b010;
  localparam logic [2:0] BIU_INCR4  = 3'b011;
  localparam logic [2:0] BIU_WRAP8  = 3'b100;
  localparam logic [2:0] BIU_INCR8  = 3'b101;
  localparam logic [2:0] BIU_WRAP16 = 3'b110;
  localparam logic [2:0] BIU_INCR16 = 3'b111;

  typedef enum logic [1:0] {IDLE, GRANT, BURST} biu_arb_state_t;

  // INCR has no defined length, so it counts as a single beat per strobe
  function automatic logic [3:0] biu_type2cnt(input logic [2:0] t);
    return t[2:1] == 2'b11 ? 4'd15 : t[2:1] == 2'b10 ? 4'd7 : t[2:1] == 2'b01 ? 4'd3 : 4'd0;
  endfunction
endpackage

// File: rtl/riscv_biu_rr_sel.sv
// riscv_biu_rr_sel: combinational round-robin picker
// Ports: req (request vector), last (previous winner) -> gnt (winner index), gnt_valid (any request)
module riscv_biu_rr_sel #(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   gnt,
  output logic            gnt_valid
);
  logic [IW-1:0] k;
  // scan farthest-first so the nearest requester after last is assigned last and wins
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    k = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IW'((int'(last) + i) % NREQ);
      if (req[k]) begin
        gnt = k;
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter: round-robin sharing of one BIU master port between NREQ requesters
// Ports: HRESETn/HCLK; req_* requester side (strobe, fields, write data in; stb/d/transfer acks, err out;
//        read data and returned address broadcast); mst_* bridge side (muxed request out; acks, err, data in)
module riscv_biu_arbiter
  import riscv_mpsoc_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PLEN = 64,
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic            HRESETn,
  input  logic            HCLK,
  input  logic [NREQ-1:0] req_stb_i,
  output logic [NREQ-1:0] req_stb_ack_o,
  output logic [NREQ-1:0] req_d_ack_o,
  output logic [NREQ-1:0] req_ack_o,
  output logic [NREQ-1:0] req_err_o,
  input  logic [PLEN-1:0] req_adri_i [NREQ],
  input  logic [2:0]      req_size_i [NREQ],
  input  logic [2:0]      req_type_i [NREQ],
  input  logic [2:0]      req_prot_i [NREQ],
  input  logic [NREQ-1:0] req_lock_i,
  input  logic [NREQ-1:0] req_we_i,
  input  logic [XLEN-1:0] req_d_i [NREQ],
  output logic [XLEN-1:0] req_q_o,
  output logic [PLEN-1:0] req_adro_o,
  output logic            mst_stb_o,
  output logic [PLEN-1:0] mst_adri_o,
  output logic [2:0]      mst_size_o,
  output logic [2:0]      mst_type_o,
  output logic [2:0]      mst_prot_o,
  output logic            mst_lock_o,
  output logic            mst_we_o,
  output logic [XLEN-1:0] mst_d_o,
  input  logic            mst_stb_ack_i,
  input  logic            mst_d_ack_i,
  input  logic            mst_ack_i,
  input  logic            mst_err_i,
  input  logic [XLEN-1:0] mst_q_i,
  input  logic [PLEN-1:0] mst_adro_i
);
  biu_arb_state_t state, state_n;
  logic [IW-1:0] aph_owner, aph_owner_n, dph_owner, dph_owner_n, last_grant, last_grant_n, gnt;
  logic [4:0] beats, beats_n;
  logic gnt_valid, active;

  riscv_biu_rr_sel #(.NREQ(NREQ)) u_sel (
    .req(req_stb_i),
    .last(last_grant),
    .gnt(gnt),
    .gnt_valid(gnt_valid)
  );

  assign active     = state != IDLE;
  assign mst_stb_o  = active & req_stb_i[aph_owner];
  assign mst_adri_o = active ? req_adri_i[aph_owner] : '0;
  assign mst_size_o = active ? req_size_i[aph_owner] : '0;
  assign mst_type_o = active ? req_type_i[aph_owner] : '0;
  assign mst_prot_o = active ? req_prot_i[aph_owner] : '0;
  assign mst_lock_o = active & req_lock_i[aph_owner];
  assign mst_we_o   = active & req_we_i[aph_owner];
  assign mst_d_o    = req_d_i[aph_owner];
  assign req_q_o    = mst_q_i;
  assign req_adro_o = mst_adro_i;

  // address-phase acks go to aph_owner, transfer ack/err to the owner of the last data beat
  always_comb begin
    req_stb_ack_o = '0;
    req_d_ack_o = '0;
    req_ack_o = '0;
    req_err_o = '0;
    req_stb_ack_o[aph_owner] = mst_stb_ack_i & (state == GRANT);
    req_d_ack_o[aph_owner] = mst_d_ack_i & (state == BURST);
    req_ack_o[dph_owner] = mst_ack_i;
    req_err_o[dph_owner] = mst_err_i;
  end

  always_comb begin
    state_n = state;
    aph_owner_n = aph_owner;
    dph_owner_n = dph_owner;
    last_grant_n = last_grant;
    beats_n = beats;
    case (state)
      IDLE: if (gnt_valid) begin
        aph_owner_n = gnt;
        last_grant_n = gnt;
        state_n = GRANT;
      end
      GRANT: begin
        if (mst_stb_ack_i) begin
          beats_n = {1'b0, biu_type2cnt(mst_type_o)} + 5'd1;
          state_n = BURST;
        end else if (!req_stb_i[aph_owner]) state_n = IDLE;
      end
      BURST: if (mst_d_ack_i) begin
        beats_n = beats - 5'd1;
        dph_owner_n = aph_owner;
        if (beats == 5'd1) state_n = req_lock_i[aph_owner] ? GRANT : IDLE;
      end
      default: state_n = IDLE;
    endcase
    // an error aborts whatever is in flight; a held lock keeps the owner
    if (mst_err_i) begin
      beats_n = '0;
      aph_owner_n = aph_owner;
      last_grant_n = last_grant;
      state_n = req_lock_i[aph_owner] ? GRANT : IDLE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      aph_owner <= '0;
      dph_owner <= '0;
      last_grant <= IW'(NREQ - 1);
      beats <= '0;
    end else begin
      state <= state_n;
      aph_owner <= aph_owner_n;
      dph_owner <= dph_owner_n;
      last_grant <= last_grant_n;
      beats <= beats_n;
    end
endmodule
